// File: rtl/matrix_pkg.sv
// Shared matrix geometry and load/stream FSM encoding.
// Used by mat_load_ctrl and by the mult_M datapath.
package matrix_pkg;

  localparam int N      = 5;
  localparam int ELEM_W = 8;
  localparam int NELEM  = N * N;
  localparam int MAT_W  = NELEM * ELEM_W;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    CAPTURE = 2'd2,
    STREAM  = 2'd3
  } state_t;

endpackage

// File: rtl/mat_idx_ctr.sv
// Element index counter shared by the load and stream paths.
// clear wins over inc; wrap flags the last element.
module mat_idx_ctr #(
  parameter int NELEM = 25,
  parameter int IW    = $clog2(NELEM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clear,
  output logic [IW-1:0] idx,
  output logic          wrap
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      idx <= '0;
    else if (clear)
      idx <= '0;
    else if (inc)
      idx <= idx + 1'b1;
  end

  assign wrap = (idx == IW'(NELEM - 1));

endmodule

// File: rtl/mult_M.sv
// Combinational signed N x N matrix multiply, truncated elements.
// ovf flags any element whose full sum does not fit ELEM_W.
module mult_M
  import matrix_pkg::*;
(
  input  logic [MAT_W-1:0] a,
  input  logic [MAT_W-1:0] b,
  output logic [MAT_W-1:0] p,
  output logic             ovf
);

  localparam int MAXV = (1 << (ELEM_W - 1)) - 1;
  localparam int MINV = -(1 << (ELEM_W - 1));

  always_comb begin
    int acc;
    logic signed [ELEM_W-1:0] ea;
    logic signed [ELEM_W-1:0] eb;
    p   = '0;
    ovf = 1'b0;
    acc = 0;
    ea  = '0;
    eb  = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int k = 0; k < N; k++) begin
          ea  = a[MAT_W-1-(i*N+k)*ELEM_W -: ELEM_W];
          eb  = b[MAT_W-1-(k*N+j)*ELEM_W -: ELEM_W];
          acc = acc + int'(ea) * int'(eb);
        end
        p[MAT_W-1-(i*N+j)*ELEM_W -: ELEM_W] = acc[ELEM_W-1:0];
        if (acc > MAXV || acc < MINV)
          ovf = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mat_load_ctrl.sv
// Operand loader and result streamer around an external mult_M.
// Loads A then B, captures the product, streams it element-wise.
module mat_load_ctrl
  import matrix_pkg::*;
#(
  parameter int N      = matrix_pkg::N,
  parameter int ELEM_W = matrix_pkg::ELEM_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  abort,
  input  logic [ELEM_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N*N*ELEM_W-1:0] lin,
  output logic [N*N*ELEM_W-1:0] col,
  input  logic [N*N*ELEM_W-1:0] n_out,
  input  logic                  ovf,
  output logic [ELEM_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_ovf,
  output logic                  busy
);

  localparam int NE = N * N;
  localparam int MW = NE * ELEM_W;
  localparam int IW = $clog2(NE);

  state_t          state;
  state_t          nxt;
  logic [IW-1:0]   idx;
  logic            wrap;
  logic            inc;
  logic            clr;
  logic            wr_a;
  logic            wr_b;
  logic            cap;
  logic [MW-1:0]   result;

  mat_idx_ctr #(.NELEM(NE), .IW(IW)) u_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .clear (clr),
    .idx   (idx),
    .wrap  (wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= LOAD_A;
    else
      state <= nxt;
  end

  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    inc       = 1'b0;
    clr       = 1'b0;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    cap       = 1'b0;
    unique case (state)
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_a = 1'b1;
          if (wrap) begin
            clr = 1'b1;
            nxt = LOAD_B;
          end else begin
            inc = 1'b1;
          end
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_b = 1'b1;
          if (wrap) begin
            clr = 1'b1;
            nxt = CAPTURE;
          end else begin
            inc = 1'b1;
          end
        end
      end
      CAPTURE: begin
        cap = 1'b1;
        nxt = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (wrap) begin
            clr = 1'b1;
            nxt = LOAD_A;
          end else begin
            inc = 1'b1;
          end
        end
      end
      default: nxt = LOAD_A;
    endcase
    // Abort abandons the transaction but keeps every data register.
    if (abort) begin
      nxt  = LOAD_A;
      clr  = 1'b1;
      inc  = 1'b0;
      wr_a = 1'b0;
      wr_b = 1'b0;
      cap  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lin     <= '0;
      col     <= '0;
      result  <= '0;
      out_ovf <= 1'b0;
    end else begin
      if (wr_a)
        lin[MW-1-int'(idx)*ELEM_W -: ELEM_W] <= in_data;
      if (wr_b)
        col[MW-1-int'(idx)*ELEM_W -: ELEM_W] <= in_data;
      if (cap) begin
        result  <= n_out;
        out_ovf <= ovf;
      end
    end
  end

  assign out_data = result[MW-1-int'(idx)*ELEM_W -: ELEM_W];
  assign busy     = !(state == LOAD_A && idx == '0);

endmodule
